// File: rtl/int2flt_core_if.sv
// Status bundle for int2flt_core: carries the completion flag.
interface int2flt_core_if;
    logic done;

    modport master (output done);
    modport slave  (input  done);
endinterface

// File: rtl/int2flt_core.sv
// Sign-magnitude int16 to half-precision converter working through data memory.
// Optional INT2FLT_FAST_NORM_EN: single-cycle normalisation (priority encoder + barrel shift).
module int2flt_dmem (
    input  logic       clk,
    input  logic       we,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata
);
    logic [7:0] my_memory [0:255];

    always_ff @(posedge clk) begin
        if (we) my_memory[addr] <= wdata;
    end

    assign rdata = my_memory[addr];
endmodule

module int2flt_core (
    input  logic                  clk,
    input  logic                  reset,
    int2flt_core_if.master        ctl
);
    typedef enum logic [2:0] {
        LD_HI, LD_LO, NORM, ROUND, ST_HI, ST_LO, DONE
    } state_e;

    state_e      state_q, state_d;
    logic [14:0] mag_q, mag_d;
    logic        sign_q, sign_d;
    logic [4:0]  exp_q, exp_d;
    logic [9:0]  mant_q, mant_d;

    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic [14:0] lo_mag;
    logic        rnd_up;
    logic [11:0] sig_inc;

    int2flt_dmem dm1 (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    assign lo_mag  = {mag_q[14:8], mem_rdata};
    // Nearest-even: bit 4 is the kept LSB, bit 3 the guard, bits 2:0 sticky
    assign rnd_up  = mag_q[3] & (mag_q[4] | (|mag_q[2:0]));
    assign sig_inc = {1'b0, mag_q[14:4]} + {11'd0, rnd_up};

`ifdef INT2FLT_FAST_NORM_EN
    logic [3:0] lz;

    always_comb begin
        lz = 4'd0;
        for (int i = 0; i < 15; i++) begin
            if (mag_q[i]) lz = 4'(14 - i);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LD_HI;
            mag_q   <= '0;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            mant_q  <= '0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            mant_q  <= mant_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mag_d     = mag_q;
        sign_d    = sign_q;
        exp_d     = exp_q;
        mant_d    = mant_q;
        mem_we    = 1'b0;
        mem_addr  = 8'd0;
        mem_wdata = 8'd0;
        unique case (state_q)
            LD_HI: begin
                mem_addr = 8'd1;
                sign_d   = mem_rdata[7];
                mag_d    = {mem_rdata[6:0], 8'h00};
                state_d  = LD_LO;
            end
            LD_LO: begin
                mem_addr = 8'd2;
                mag_d    = lo_mag;
                if (lo_mag == 15'd0) begin
                    exp_d   = 5'd0;
                    state_d = ROUND;
                end else begin
                    exp_d = 5'd29;
`ifdef INT2FLT_FAST_NORM_EN
                    state_d = NORM;
`else
                    state_d = lo_mag[14] ? ROUND : NORM;
`endif
                end
            end
            NORM: begin
`ifdef INT2FLT_FAST_NORM_EN
                mag_d   = mag_q << lz;
                exp_d   = exp_q - {1'b0, lz};
                state_d = ROUND;
`else
                // Look one bit ahead so each NORM cycle is exactly one shift
                mag_d = mag_q << 1;
                exp_d = exp_q - 5'd1;
                if (mag_q[13]) state_d = ROUND;
`endif
            end
            ROUND: begin
                if (sig_inc[11]) begin
                    exp_d  = exp_q + 5'd1;
                    mant_d = sig_inc[10:1];
                end else begin
                    mant_d = sig_inc[9:0];
                end
                state_d = ST_HI;
            end
            ST_HI: begin
                mem_we    = ~reset;
                mem_addr  = 8'd5;
                mem_wdata = {sign_q, exp_q, mant_q[9:8]};
                state_d   = ST_LO;
            end
            ST_LO: begin
                mem_we    = ~reset;
                mem_addr  = 8'd6;
                mem_wdata = mant_q[7:0];
                state_d   = DONE;
            end
            DONE: state_d = DONE;
            default: state_d = LD_HI;
        endcase
    end

    assign ctl.done = (state_q == DONE);
endmodule

// File: tb/tb_int2flt_core.sv
// Directed and random checks for int2flt_core through its data memory.
module tb_int2flt_core;
    logic clk;
    logic reset;
    int   checks;
    int   failures;
    logic [15:0]  v;
    int unsigned  r;
    int           sh;

    int2flt_core_if ctl ();

    int2flt_core dut (
        .clk   (clk),
        .reset (reset),
        .ctl   (ctl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int msb_pos(input logic [15:0] x);
        int p;
        p = -1;
        for (int i = 0; i < 15; i++) if (x[i]) p = i;
        return p;
    endfunction

    function automatic logic [15:0] ref_conv(input logic [15:0] x);
        int mag, p, e, sig, s, g, st;
        mag = int'(x[14:0]);
        p   = msb_pos(x);
        if (p < 0) return {x[15], 15'd0};
        e = 15 + p;
        if (p <= 10) begin
            sig = mag << (10 - p);
        end else begin
            s   = p - 10;
            sig = mag >> s;
            g   = (mag >> (s - 1)) & 1;
            st  = ((mag & ((1 << (s - 1)) - 1)) != 0) ? 1 : 0;
            if (g == 1 && ((sig & 1) == 1 || st == 1)) sig = sig + 1;
            if (sig >= 2048) begin
                e   = e + 1;
                sig = sig >> 1;
            end
        end
        return {x[15], 5'(e), 10'(sig & 1023)};
    endfunction

    function automatic int exp_lat(input logic [15:0] x);
        int p;
        p = msb_pos(x);
        if (p < 0) return 5;
`ifdef INT2FLT_FAST_NORM_EN
        return 6;
`else
        return 5 + (14 - p);
`endif
    endfunction

    task automatic convert(input logic [15:0] x, input logic [15:0] exp,
                           input string tag);
        int n;
        reset = 1'b1;
        @(negedge clk);
        chk({tag, "_done_in_reset"}, int'(ctl.done), 0);
        dut.dm1.my_memory[1] = x[15:8];
        dut.dm1.my_memory[2] = x[7:0];
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        while (ctl.done !== 1'b1 && n < 25) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, int'(ctl.done), 1);
        chk({tag, "_latency"}, n, exp_lat(x));
        chk({tag, "_result"},
            int'({dut.dm1.my_memory[5], dut.dm1.my_memory[6]}), int'(exp));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        dut.dm1.my_memory[0] = 8'h11;
        dut.dm1.my_memory[3] = 8'h33;
        dut.dm1.my_memory[4] = 8'h44;
        dut.dm1.my_memory[7] = 8'h77;
        dut.dm1.my_memory[5] = 8'hA5;
        dut.dm1.my_memory[6] = 8'hA5;
        dut.dm1.my_memory[1] = 8'h00;
        dut.dm1.my_memory[2] = 8'h01;
        repeat (3) @(negedge clk);
        chk("reset_done", int'(ctl.done), 0);
        chk("reset_state", int'(dut.state_q), 0);
        chk("reset_nowrite",
            int'({dut.dm1.my_memory[5], dut.dm1.my_memory[6]}), 16'hA5A5);

        convert(16'h0000, 16'h0000, "zero");
        convert(16'h0001, 16'h3C00, "one");
        convert(16'h0003, 16'h4200, "three");
        convert(16'h8001, 16'hBC00, "neg_one");
        convert(16'h7FFF, 16'h7800, "max_ovf");
        convert(16'h1FFF, 16'h7000, "ovf_1fff");
        convert(16'h1002, 16'h6C00, "tie_even");
        convert(16'h1006, 16'h6C02, "tie_odd");
        convert(16'h782F, 16'h7783, "sticky");
        convert(16'h8400, 16'hE400, "neg_p10");

        repeat (3) @(negedge clk);
        chk("done_held", int'(ctl.done), 1);

        // Abort a conversion partway through, then restart on new operands
        reset = 1'b1;
        @(negedge clk);
        dut.dm1.my_memory[1] = 8'h00;
        dut.dm1.my_memory[2] = 8'h01;
        reset = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_done_low", int'(ctl.done), 0);
        convert(16'h0030, 16'h5200, "after_abort");

        for (int k = 0; k < 24; k++) begin
            r  = $urandom;
            sh = int'($urandom_range(0, 15));
            v  = 16'(r) >> sh;
            v[15] = 1'($urandom_range(0, 1));
            convert(v, ref_conv(v), $sformatf("rand%0d_%04h", k, v));
        end

        chk("untouched0", int'(dut.dm1.my_memory[0]), 8'h11);
        chk("untouched3", int'(dut.dm1.my_memory[3]), 8'h33);
        chk("untouched4", int'(dut.dm1.my_memory[4]), 8'h44);
        chk("untouched7", int'(dut.dm1.my_memory[7]), 8'h77);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
